// File: rtl/projectile_pool_pkg.sv
// Shared game constants for the invaders playfield and helpers used by the
// projectile and invader-AI blocks.
package projectile_pool_pkg;

    localparam int SCREEN_W         = 640;
    localparam int SCREEN_H         = 480;
    localparam int DEF_NUM_SLOTS    = 4;
    localparam int DEF_COORD_W      = 10;
    localparam int DEF_STEP         = 4;
    localparam int DEF_LIMIT_Y      = SCREEN_H - 1;
    localparam int DEF_COOLDOWN     = 8;
    // Spawn offsets relative to the firing sprite's origin.
    localparam int PLAYER_SPAWN_DY  = 8;
    localparam int INVADER_SPAWN_DY = 16;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/projectile_pool_lowest_free_slot.sv
// Combinational priority finder: one-hot of the lowest set bit of free, plus
// a flag telling whether any bit was set.
module lowest_free_slot
    import projectile_pool_pkg::*;
#(
    parameter int N = DEF_NUM_SLOTS
) (
    input  logic [N-1:0] free,
    output logic [N-1:0] onehot,
    output logic         valid
);

    always_comb begin
        onehot = '0;
        valid  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (free[i] && !valid) begin
                onehot[i] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/projectile_pool.sv
// Projectile manager: spawns into the lowest free slot on frame with a
// frame-based cooldown, and steps live projectiles vertically once per frame.
module projectile_pool
    import projectile_pool_pkg::*;
#(
    parameter int NUM_SLOTS       = DEF_NUM_SLOTS,
    parameter int COORD_W         = DEF_COORD_W,
    parameter int STEP            = DEF_STEP,
    parameter int DIR_UP          = 1,
    parameter int LIMIT_Y         = DEF_LIMIT_Y,
    parameter int COOLDOWN_FRAMES = DEF_COOLDOWN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame,
    input  logic                         fire,
    input  logic [COORD_W-1:0]           spawn_x,
    input  logic [COORD_W-1:0]           spawn_y,
    input  logic [NUM_SLOTS-1:0]         hit,
    output logic [NUM_SLOTS-1:0]         active,
    output logic [NUM_SLOTS*COORD_W-1:0] proj_x,
    output logic [NUM_SLOTS*COORD_W-1:0] proj_y,
    output logic                         fire_ack,
    output logic                         fire_drop,
    output logic [3:0]                   num_active
);

    localparam int CNT_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    logic [CNT_W-1:0]     cooldown;
    logic                 pending;
    logic [COORD_W-1:0]   hold_x;
    logic [COORD_W-1:0]   hold_y;
    logic [NUM_SLOTS-1:0] free_mask;
    logic [NUM_SLOTS-1:0] free_onehot;
    logic [NUM_SLOTS-1:0] active_next;
    logic                 free_valid;
    logic                 spawn_try;
    logic                 spawn_ok;

    // Returns {leaves_screen, stepped_y}; downward sum uses one extra bit so
    // y + STEP cannot wrap before the limit compare.
    function automatic logic [COORD_W:0] step_y(input logic [COORD_W-1:0] y);
        logic [COORD_W:0] sum;
        sum = {1'b0, y} + (COORD_W + 1)'(STEP);
        if (DIR_UP != 0) begin
            step_y = {(y < COORD_W'(STEP)), y - COORD_W'(STEP)};
        end else begin
            step_y = {(sum > (COORD_W + 1)'(LIMIT_Y)), sum[COORD_W-1:0]};
        end
    endfunction

    // A slot being hit this cycle is not free, even though it will be empty next cycle.
    assign free_mask = ~active & ~hit;

    lowest_free_slot #(.N(NUM_SLOTS)) u_free (
        .free   (free_mask),
        .onehot (free_onehot),
        .valid  (free_valid)
    );

    assign spawn_try = frame && pending && (cooldown == '0);
    assign spawn_ok  = spawn_try && free_valid;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        logic [COORD_W-1:0] x_q;
        logic [COORD_W-1:0] y_q;
        logic [COORD_W:0]   nxt;
        logic               load;
        logic               move;

        assign nxt  = step_y(y_q);
        assign load = spawn_ok && free_onehot[i];
        assign move = frame && active[i] && !hit[i];
        assign active_next[i] = load || (active[i] && !hit[i] && !(frame && nxt[COORD_W]));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                x_q <= '0;
                y_q <= '0;
            end else if (load) begin
                x_q <= hold_x;
                y_q <= hold_y;
            end else if (move && !nxt[COORD_W]) begin
                y_q <= nxt[COORD_W-1:0];
            end
        end

        assign proj_x[i*COORD_W +: COORD_W] = x_q;
        assign proj_y[i*COORD_W +: COORD_W] = y_q;
    end

    // A fire coinciding with frame is not visible to that frame; it re-arms pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active     <= '0;
            num_active <= '0;
            fire_ack   <= 1'b0;
            fire_drop  <= 1'b0;
            cooldown   <= '0;
            pending    <= 1'b0;
            hold_x     <= '0;
            hold_y     <= '0;
        end else begin
            active     <= active_next;
            num_active <= popcount8(8'(active_next));
            fire_ack   <= spawn_ok;
            fire_drop  <= spawn_try && !free_valid;
            if (spawn_ok) begin
                cooldown <= CNT_W'(COOLDOWN_FRAMES);
            end else if (frame && cooldown != '0) begin
                cooldown <= cooldown - 1'b1;
            end
            if (fire) begin
                pending <= 1'b1;
                hold_x  <= spawn_x;
                hold_y  <= spawn_y;
            end else if (spawn_try) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_projectile_pool.sv
// Scoreboard bench: two pool instances (lasers moving up with cooldown 2, bombs
// moving down with no cooldown) share stimulus and are checked against a spec-level model.
module tb_projectile_pool;

    localparam int N  = 4;
    localparam int CW = 10;

    typedef struct packed {
        logic [3:0]    act;
        logic [N*CW-1:0] px;
        logic [N*CW-1:0] py;
        logic          ack;
        logic          drop;
        logic [3:0]    cnt;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            frame = 1'b0;
    logic            fire = 1'b0;
    logic [CW-1:0]   spawn_x = '0;
    logic [CW-1:0]   spawn_y = '0;
    logic [N-1:0]    hit = '0;

    logic [N-1:0]    up_active, dn_active;
    logic [N*CW-1:0] up_px, up_py, dn_px, dn_py;
    logic            up_ack, up_drop, dn_ack, dn_drop;
    logic [3:0]      up_num, dn_num;

    int n_vec = 0;
    int n_bad = 0;

    exp_t q_up[$];
    exp_t q_dn[$];

    // Reference model state, index 0 = upward/cooldown 2, index 1 = downward/cooldown 0.
    bit [N-1:0] m_act[2];
    int         m_x[2][N];
    int         m_y[2][N];
    int         m_cnt[2];
    bit         m_pend[2];
    int         m_hx[2];
    int         m_hy[2];

    projectile_pool #(
        .NUM_SLOTS(N), .COORD_W(CW), .STEP(4), .DIR_UP(1), .LIMIT_Y(479), .COOLDOWN_FRAMES(2)
    ) u_up (
        .clk(clk), .rst(rst), .frame(frame), .fire(fire), .spawn_x(spawn_x), .spawn_y(spawn_y),
        .hit(hit), .active(up_active), .proj_x(up_px), .proj_y(up_py),
        .fire_ack(up_ack), .fire_drop(up_drop), .num_active(up_num)
    );

    projectile_pool #(
        .NUM_SLOTS(N), .COORD_W(CW), .STEP(4), .DIR_UP(0), .LIMIT_Y(479), .COOLDOWN_FRAMES(0)
    ) u_dn (
        .clk(clk), .rst(rst), .frame(frame), .fire(fire), .spawn_x(spawn_x), .spawn_y(spawn_y),
        .hit(hit), .active(dn_active), .proj_x(dn_px), .proj_y(dn_py),
        .fire_ack(dn_ack), .fire_drop(dn_drop), .num_active(dn_num)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int k, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s[inst%0d] @%0t: got %0h expected %0h", name, k, $time, got, exp);
        end
    endtask

    task automatic compare(input int k, input exp_t e, input logic [3:0] a, input logic [N*CW-1:0] px,
                           input logic [N*CW-1:0] py, input logic ak, input logic dp, input logic [3:0] na);
        check("active", k, 64'(a), 64'(e.act));
        check("proj_x", k, 64'(px), 64'(e.px));
        check("proj_y", k, 64'(py), 64'(e.py));
        check("fire_ack", k, 64'(ak), 64'(e.ack));
        check("fire_drop", k, 64'(dp), 64'(e.drop));
        check("num_active", k, 64'(na), 64'(e.cnt));
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k] = '0;
            m_cnt[k] = 0;
            m_pend[k] = 1'b0;
            m_hx[k] = 0;
            m_hy[k] = 0;
            for (int i = 0; i < N; i++) begin
                m_x[k][i] = 0;
                m_y[k][i] = 0;
            end
        end
    endtask

    task automatic model_step(input int k, input bit f, input int fx, input int fy,
                              input bit fr, input logic [N-1:0] h, output exp_t e);
        bit [N-1:0] pre;
        int slot;
        int cnt;
        pre = m_act[k];
        e = '0;
        for (int i = 0; i < N; i++) begin
            if (pre[i] && h[i]) m_act[k][i] = 1'b0;
        end
        if (fr) begin
            for (int i = 0; i < N; i++) begin
                if (pre[i] && !h[i]) begin
                    if (k == 0) begin
                        if (m_y[k][i] < 4) m_act[k][i] = 1'b0;
                        else m_y[k][i] = m_y[k][i] - 4;
                    end else begin
                        if (m_y[k][i] + 4 > 479) m_act[k][i] = 1'b0;
                        else m_y[k][i] = m_y[k][i] + 4;
                    end
                end
            end
            if (m_cnt[k] != 0) begin
                m_cnt[k] = m_cnt[k] - 1;
            end else if (m_pend[k]) begin
                slot = -1;
                for (int i = N - 1; i >= 0; i--) begin
                    if (!pre[i] && !h[i]) slot = i;
                end
                if (slot >= 0) begin
                    m_act[k][slot] = 1'b1;
                    m_x[k][slot] = m_hx[k];
                    m_y[k][slot] = m_hy[k];
                    m_cnt[k] = (k == 0) ? 2 : 0;
                    e.ack = 1'b1;
                end else begin
                    e.drop = 1'b1;
                end
                m_pend[k] = 1'b0;
            end
        end
        if (f) begin
            m_pend[k] = 1'b1;
            m_hx[k] = fx;
            m_hy[k] = fy;
        end
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (m_act[k][i]) cnt++;
            e.px[i*CW +: CW] = CW'(m_x[k][i]);
            e.py[i*CW +: CW] = CW'(m_y[k][i]);
        end
        e.act = m_act[k];
        e.cnt = 4'(cnt);
    endtask

    // Drives one cycle of inputs and queues what both pools must show after the next edge.
    task automatic cycle(input bit f, input int fx, input int fy, input bit fr, input logic [N-1:0] h);
        exp_t e;
        @(posedge clk);
        #4;
        fire = f;
        spawn_x = CW'(fx);
        spawn_y = CW'(fy);
        frame = fr;
        hit = h;
        model_step(0, f, fx, fy, fr, h, e);
        q_up.push_back(e);
        model_step(1, f, fx, fy, fr, h, e);
        q_dn.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0, '0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #4;
        fire = 1'b0;
        frame = 1'b0;
        hit = '0;
        rst = 1'b1;
        #1;
        check("rst_active", 0, 64'(up_active), 64'd0);
        check("rst_proj_y", 0, 64'(up_py), 64'd0);
        check("rst_ack_drop", 0, 64'({up_ack, up_drop}), 64'd0);
        check("rst_num", 0, 64'(up_num), 64'd0);
        check("rst_active", 1, 64'(dn_active), 64'd0);
        check("rst_proj_x", 1, 64'(dn_px), 64'd0);
        check("rst_num", 1, 64'(dn_num), 64'd0);
        model_reset();
        q_up.delete();
        q_dn.delete();
        @(posedge clk);
        #4;
        rst = 1'b0;
    endtask

    // Monitor: compares one queued expectation per instance shortly after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (q_up.size() > 0) begin
                e = q_up.pop_front();
                compare(0, e, up_active, up_px, up_py, up_ack, up_drop, up_num);
            end
            if (q_dn.size() > 0) begin
                e = q_dn.pop_front();
                compare(1, e, dn_active, dn_px, dn_py, dn_ack, dn_drop, dn_num);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();

        // Spawn then three steps.
        cycle(1'b1, 100, 440, 1'b0, '0);
        cycle(1'b0, 0, 0, 1'b1, '0);
        for (int i = 0; i < 3; i++) begin
            idle(2);
            cycle(1'b0, 0, 0, 1'b1, '0);
        end

        // Screen-edge deactivation in both directions.
        do_reset();
        cycle(1'b1, 50, 3, 1'b0, '0);
        cycle(1'b0, 0, 0, 1'b1, '0);
        cycle(1'b0, 0, 0, 1'b1, '0);
        cycle(1'b1, 60, 476, 1'b0, '0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 0, 0, 1'b1, '0);

        // Fire every cycle with frequent frames: cooldown spacing.
        do_reset();
        for (int i = 0; i < 30; i++) cycle(1'b1, 10 + i, 200, (i % 3) == 0, '0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 300, 300, 1'b1, '0);

        // Fill all slots, drop when full, then reuse a hit slot.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 20 * i, 100, 1'b0, '0);
            cycle(1'b0, 0, 0, 1'b1, '0);
        end
        cycle(1'b1, 400, 150, 1'b1, '0);
        cycle(1'b0, 0, 0, 1'b1, '0);
        cycle(1'b0, 0, 0, 1'b0, 4'b0100);
        cycle(1'b1, 222, 111, 1'b0, '0);
        cycle(1'b0, 0, 0, 1'b1, '0);

        // Hit on the frame cycle while a request pends: slot is not reused that frame.
        cycle(1'b1, 333, 99, 1'b0, '0);
        cycle(1'b0, 0, 0, 1'b1, 4'b0010);
        idle(2);

        // Reset with three live projectiles and a pending request.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 30 * i, 120, 1'b0, '0);
            cycle(1'b0, 0, 0, 1'b1, '0);
        end
        cycle(1'b1, 500, 500, 1'b0, '0);
        do_reset();
        cycle(1'b0, 0, 0, 1'b1, '0);
        idle(2);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                cycle(($urandom_range(0, 3) == 0), int'($urandom_range(0, 1023)),
                      ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 479)),
                      ($urandom_range(0, 4) == 0),
                      ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 15)) : N'(0));
            end
        end

        idle(2);
        @(posedge clk);
        #5;
        check("queue_drained", 0, 64'(q_up.size() + q_dn.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/projectile_pool.md
# projectile_pool

Parametrised projectile manager: owns up to NUM_SLOTS simultaneous projectiles, spawns them on fire requests subject to a frame-based cooldown, and steps them vertically once per frame. Instanced once for the player's lasers (DIR_UP=1) and once for invader bombs (DIR_UP=0). Sits between the input/invader-AI logic and the collision detector and sprite renderer.

## Interface
Parameters:
- NUM_SLOTS, 4: simultaneous projectiles (1..8)
- COORD_W, 10: coordinate width
- STEP, 4: pixels moved per frame
- DIR_UP, 1: 1 = move toward y=0, 0 = move toward LIMIT_Y
- LIMIT_Y, 479: bottom boundary for DIR_UP=0
- COOLDOWN_FRAMES, 8: frames blocked after a spawn (0 = none)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- frame  in  1  one-cycle pulse at start of blanking
- fire  in  1  one-cycle spawn request (debounced/edge-detected upstream)
- spawn_x  in  COORD_W  spawn x, sampled with fire
- spawn_y  in  COORD_W  spawn y, sampled with fire
- hit  in  NUM_SLOTS  per-slot collision from collision detector
- active  out  NUM_SLOTS  slot i holds a live projectile
- proj_x  out  NUM_SLOTS*COORD_W  slot i at [i*COORD_W +: COORD_W]
- proj_y  out  NUM_SLOTS*COORD_W  same packing
- fire_ack  out  1  one-cycle pulse: pending request spawned
- fire_drop  out  1  one-cycle pulse: pending request discarded
- num_active  out  4  popcount of active

## Operation
- Reset: active, proj_x, proj_y, fire_ack, fire_drop, num_active, cooldown counter, pending flag all 0.
- fire: sets pending and captures spawn_x/spawn_y into holding regs; a second fire before the next frame overwrites the coordinates (latest wins), no extra ack.
- hit[i] while active[i]: active[i] cleared next cycle, any cycle. hit[i] on an inactive slot ignored. Coordinates hold their last value.
- On frame, in this order using pre-frame state:
  - Move: each active slot without hit this cycle: DIR_UP=1: y < STEP -> deactivate, else y -= STEP. DIR_UP=0: y + STEP > LIMIT_Y (computed COORD_W+1 bits) -> deactivate, else y += STEP. x unchanged.
  - Cooldown: if counter != 0, decrement; no spawn this frame.
  - Spawn: if pending and counter == 0: free = ~active & ~hit (pre-frame); lowest-index free slot loads held coordinates, active set, counter <= COOLDOWN_FRAMES, fire_ack pulses. No free slot -> fire_drop pulses. Either way pending clears.
  - A blocked-by-cooldown request stays pending until a frame with counter == 0.
- Newly spawned slot is not moved in its spawn frame.
- fire and frame in the same cycle: fire is not seen by that frame; it pends for the next.
- num_active registered popcount of next active value.

## Timing
- fire -> spawn: at the first frame with counter 0; active/proj_* and fire_ack visible the cycle after that frame pulse.
- Movement/deactivation: outputs update one cycle after frame.
- Hit -> active low: one cycle.
- Minimum frame spacing between spawns: COOLDOWN_FRAMES+1.
- Async rst mid-frame clears all state immediately; first frame after release acts on an empty pool.

## Structure
- Shared game constants package: STEP defaults, screen limits, player/invader spawn offsets, slot count defaults.
- Sub-module lowest_free_slot: combinational one-hot priority finder (NUM_SLOTS in, one-hot + valid out), reused by invader AI.
- Per-slot registers in a generate loop; single cooldown counter, sized $clog2(COOLDOWN_FRAMES+1).

## Test plan
- Reset then fire(x=100,y=440), frame -> slot0 active, (100,440), fire_ack; next 3 frames -> y=436,432,428.
- DIR_UP=1, slot at y=3 (STEP 4), frame -> deactivated, no wrap to 1023; DIR_UP=0, LIMIT_Y=479, y=476, frame -> deactivated.
- COOLDOWN_FRAMES=2: fire every cycle -> spawns on frames 1,4,7; never two within 3 frames.
- COOLDOWN_FRAMES=0, 4 slots full, fire + frame -> fire_drop, active unchanged; hit[2] then fire+frame -> slot2 reused.
- hit[1] same cycle as frame with slot1 active -> slot1 cleared, not moved, not reallocated that frame.
- Assert rst while 3 slots active and request pending -> all outputs 0 immediately; no spawn on next frame.
